// File: rtl/flag_capture_unit.sv
// Flag capture with sticky accumulation, IRQ request/acknowledge FSM and optional per-flag event counters.
// Define FLAG_CAPTURE_COUNTERS_EN to build the four saturating counters behind cnt_out.
module flag_capture_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       flag_in,
    input  logic             flag_valid,
    input  logic [3:0]       irq_mask,
    input  logic             irq_ack,
    input  logic             clr,
    input  logic [1:0]       rd_sel,
    output logic [3:0]       flag_q,
    output logic [3:0]       flag_sticky,
    output logic             irq,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [FLAG_W-1:0] flag_cap_q, flag_cap_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              irq_q, irq_d;
    logic [FLAG_W-1:0] set_bits;
    logic [FLAG_W-1:0] clear_bits;
    logic              ack_accept;
    logic              masked_pend;

    assign masked_pend = |(sticky_q & irq_mask);

    // IRQ handshake; only an ack seen in PEND clears the masked sticky bits
    always_comb begin
        state_d    = state_q;
        ack_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (masked_pend) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (irq_ack) begin
                    state_d    = ST_HOLD;
                    ack_accept = 1'b1;
                end else if (!masked_pend) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!irq_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Incoming set bits are OR'ed last so they win over any same-cycle clear
    always_comb begin
        set_bits   = flag_valid ? flag_in : '0;
        clear_bits = clr ? '1 : (ack_accept ? irq_mask : '0);
        sticky_d   = (sticky_q & ~clear_bits) | set_bits;
        flag_cap_d = flag_valid ? flag_in : flag_cap_q;
        irq_d      = (state_d == ST_PEND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            flag_cap_q <= '0;
            sticky_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            flag_cap_q <= flag_cap_d;
            sticky_q   <= sticky_d;
            irq_q      <= irq_d;
        end
    end

    assign flag_q      = flag_cap_q;
    assign flag_sticky = sticky_q;
    assign irq         = irq_q;

`ifdef FLAG_CAPTURE_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [FLAG_W];
    logic [CNT_W-1:0] cnt_d [FLAG_W];

    // Saturating event counters; clr reloads with this cycle's event so none is lost
    always_comb begin
        for (int i = 0; i < int'(FLAG_W); i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = CNT_W'(flag_valid & flag_in[i]);
            end else if (flag_valid && flag_in[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FLAG_W); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(FLAG_W); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt_out = cnt_q[rd_sel];
`else
    logic unused_rd_sel;

    assign unused_rd_sel = ^rd_sel;
    assign cnt_out       = '0;
`endif

endmodule

// File: tb/tb_flag_capture_unit.sv
// Directed bench for flag_capture_unit: capture, sticky, IRQ handshake, counters and reset.
module tb_flag_capture_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       flag_in;
    logic             flag_valid;
    logic [3:0]       irq_mask;
    logic             irq_ack;
    logic             clr;
    logic [1:0]       rd_sel;
    logic [3:0]       flag_q;
    logic [3:0]       flag_sticky;
    logic             irq;
    logic [CNT_W-1:0] cnt_out;

    int checks = 0;
    int errors = 0;

    flag_capture_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flag_in     (flag_in),
        .flag_valid  (flag_valid),
        .irq_mask    (irq_mask),
        .irq_ack     (irq_ack),
        .clr         (clr),
        .rd_sel      (rd_sel),
        .flag_q      (flag_q),
        .flag_sticky (flag_sticky),
        .irq         (irq),
        .cnt_out     (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter value depends on whether the counters are built
    function automatic logic [31:0] ecnt(input int v);
`ifdef FLAG_CAPTURE_COUNTERS_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] sel, input int v);
        rd_sel = sel;
        #1;
        chk(tag, 32'(cnt_out), ecnt(v));
    endtask

    initial begin
        reset = 1'b1; flag_in = 4'h0; flag_valid = 1'b0; irq_mask = 4'h0;
        irq_ack = 1'b0; clr = 1'b0; rd_sel = 2'd0;
        tick(); tick();
        chk("rst_flag_q", 32'(flag_q), 32'h0);
        chk("rst_sticky", 32'(flag_sticky), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk_cnt("rst_cnt0", 2'd0, 0);
        reset = 1'b0;
        tick();

        // Basic capture and IRQ latency
        irq_mask = 4'b0001; flag_in = 4'b0101; flag_valid = 1'b1;
        tick();
        flag_valid = 1'b0; flag_in = 4'b0000;
        chk("cap_flag_q", 32'(flag_q), 32'h5);
        chk("cap_sticky", 32'(flag_sticky), 32'h5);
        chk("cap_irq_n1", 32'(irq), 32'h0);
        chk_cnt("cap_cnt0", 2'd0, 1);
        chk_cnt("cap_cnt1", 2'd1, 0);
        chk_cnt("cap_cnt2", 2'd2, 1);
        tick();
        chk("cap_irq_n2", 32'(irq), 32'h1);
        chk("hold_flag_q", 32'(flag_q), 32'h5);

        // Acknowledge clears masked bits, HOLD then IDLE
        irq_ack = 1'b1;
        tick();
        chk("ack_irq", 32'(irq), 32'h0);
        chk("ack_sticky", 32'(flag_sticky), 32'h4);
        tick();
        chk("hold_sticky", 32'(flag_sticky), 32'h4);
        chk("hold_irq", 32'(irq), 32'h0);
        irq_ack = 1'b0;
        tick();
        chk("rel_irq", 32'(irq), 32'h0);
        tick();
        chk("idle_irq", 32'(irq), 32'h0);

        // New flag set during ack wins over the clear, re-raises after release
        flag_valid = 1'b1; flag_in = 4'b0001;
        tick();
        flag_valid = 1'b0;
        tick();
        chk("pend2_irq", 32'(irq), 32'h1);
        irq_ack = 1'b1; flag_valid = 1'b1; flag_in = 4'b0001;
        tick();
        flag_valid = 1'b0; flag_in = 4'b0000;
        chk("ackset_sticky", 32'(flag_sticky), 32'h5);
        chk("ackset_irq", 32'(irq), 32'h0);
        tick();
        irq_ack = 1'b0;
        tick();
        chk("rerase_irq_c1", 32'(irq), 32'h0);
        tick();
        chk("rerase_irq_c2", 32'(irq), 32'h1);
        chk_cnt("cnt0_three", 2'd0, 3);

        // Mask change drops PEND without ack and leaves sticky intact
        irq_mask = 4'b0010;
        tick();
        chk("maskdrop_irq", 32'(irq), 32'h0);
        chk("maskdrop_sticky", 32'(flag_sticky), 32'h5);

        // clr with simultaneous capture
        irq_mask = 4'b0000; flag_valid = 1'b1; flag_in = 4'b0010;
        tick();
        chk("pre_clr_sticky", 32'(flag_sticky), 32'h7);
        clr = 1'b1; flag_in = 4'b1000;
        tick();
        clr = 1'b0; flag_valid = 1'b0; flag_in = 4'b0000;
        chk("clr_sticky", 32'(flag_sticky), 32'h8);
        chk("clr_flag_q", 32'(flag_q), 32'h8);
        chk_cnt("clr_cnt0", 2'd0, 0);
        chk_cnt("clr_cnt1", 2'd1, 0);
        chk_cnt("clr_cnt2", 2'd2, 0);
        chk_cnt("clr_cnt3", 2'd3, 1);

        // Saturation of a 4-bit counter
        rd_sel = 2'd1; flag_valid = 1'b1; flag_in = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_cnt1_%0d", k), 32'(cnt_out), ecnt((k > 15) ? 15 : k));
        end
        flag_valid = 1'b0; flag_in = 4'b0000;
        tick();
        chk("sat_hold", 32'(cnt_out), ecnt(15));
        chk_cnt("sat_cnt0", 2'd0, 0);
        chk("sat_irq", 32'(irq), 32'h0);

        // clr in PEND: irq falls once the masked sticky is empty
        irq_mask = 4'b1000;
        tick();
        tick();
        chk("clrpend_irq_on", 32'(irq), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrpend_sticky", 32'(flag_sticky), 32'h0);
        tick();
        chk("clrpend_irq_off", 32'(irq), 32'h0);

        // Reset in HOLD with ack high and all sticky bits set
        irq_mask = 4'b1111; flag_valid = 1'b1; flag_in = 4'b0101;
        tick();
        flag_valid = 1'b0;
        tick();
        chk("h_pend_irq", 32'(irq), 32'h1);
        irq_ack = 1'b1; flag_valid = 1'b1; flag_in = 4'b1111;
        tick();
        flag_valid = 1'b0; flag_in = 4'b0000;
        chk("h_sticky", 32'(flag_sticky), 32'hF);
        chk("h_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        tick();
        chk("hrst_flag_q", 32'(flag_q), 32'h0);
        chk("hrst_sticky", 32'(flag_sticky), 32'h0);
        chk("hrst_irq", 32'(irq), 32'h0);
        chk_cnt("hrst_cnt1", 2'd1, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_irq1", 32'(irq), 32'h0);
        tick();
        chk("post_rst_irq2", 32'(irq), 32'h0);
        chk("post_rst_sticky", 32'(flag_sticky), 32'h0);
        irq_ack = 1'b0; irq_mask = 4'b0001; flag_valid = 1'b1; flag_in = 4'b0001;
        tick();
        flag_valid = 1'b0; flag_in = 4'b0000;
        chk("new_cap_irq_n1", 32'(irq), 32'h0);
        tick();
        chk("new_cap_irq_n2", 32'(irq), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_capture_unit.md
FLAG_CAPTURE_UNIT -- requirements
Module: flag_capture_unit

Interface
REQ-001 Parameter CNT_W, default 8, width of each per-flag event counter (range 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flag_in  input  4  selected flag vector from the upstream flag multiplexer.
REQ-005 flag_valid  input  1  flag_in qualifier; one capture per high cycle.
REQ-006 irq_mask  input  4  per-bit interrupt enable; 1 = bit may raise irq.
REQ-007 irq_ack  input  1  interrupt acknowledge level from consumer.
REQ-008 clr  input  1  clears sticky flags and counters.
REQ-009 rd_sel  input  2  selects counter shown on cnt_out.
REQ-010 flag_q  output  4  last captured flag vector.
REQ-011 flag_sticky  output  4  OR-accumulated flags since last clear or ack.
REQ-012 irq  output  1  registered interrupt request.
REQ-013 cnt_out  output  CNT_W  counter value for flag bit rd_sel.

Function
REQ-014 flag_valid=1 in cycle N: flag_q = flag_in, visible from cycle N+1; flag_valid=0 holds flag_q.
REQ-015 Sticky update per edge: sticky_next = (sticky & ~clear_bits) | (flag_valid ? flag_in : 0); incoming set bits always win over any clear in the same cycle.
REQ-016 clear_bits = 4'hF when clr=1; = irq_mask when FSM accepts irq_ack (REQ-019); otherwise 0.
REQ-017 IRQ FSM states: IDLE (irq=0), PEND (irq=1), HOLD (irq=0); irq is a registered decode of the state.
REQ-018 IDLE -> PEND when (flag_sticky & irq_mask) != 0 in current cycle; capture in cycle N therefore raises irq in cycle N+2.
REQ-019 PEND -> HOLD when irq_ack=1; masked sticky bits cleared on the same edge.
REQ-020 PEND -> IDLE when (flag_sticky & irq_mask) becomes 0 via clr or mask change, without ack.
REQ-021 HOLD -> IDLE when irq_ack=0; new flags in HOLD accumulate and re-raise irq via IDLE no earlier than 2 cycles after ack release.
REQ-022 irq_ack in IDLE or HOLD has no effect on sticky bits.
REQ-023 Counter i increments by 1 on each edge where flag_valid & flag_in[i]; saturates at 2^CNT_W-1, never wraps.
REQ-024 clr with simultaneous increment: counter i loads flag_valid & flag_in[i] (0 or 1).
REQ-025 cnt_out is combinational from the selected counter register; zero latency from rd_sel.

Reset
REQ-026 reset=1 at an edge: flag_q=0, flag_sticky=0, all counters=0, FSM=IDLE, irq=0; overrides flag_valid, clr, irq_ack.
REQ-027 Reset mid-handshake (PEND or HOLD) returns FSM to IDLE; irq low from the next cycle; a still-high irq_ack after reset is ignored.

Configuration
REQ-028 Macro FLAG_CAPTURE_COUNTERS_EN: when defined, four CNT_W counters and cnt_out behave per REQ-023..025.
REQ-029 Without FLAG_CAPTURE_COUNTERS_EN: no counter registers synthesized, cnt_out tied to 0, rd_sel ignored; all other behaviour identical.

Verification
REQ-030 Reset, then flag_in=4'b0101 with flag_valid one cycle, irq_mask=4'b0001 -> flag_q=0101 and flag_sticky=0101 next cycle, irq=1 one cycle later.
REQ-031 In PEND assert irq_ack -> next cycle irq=0, flag_sticky=0100, state HOLD; drop irq_ack -> IDLE, irq stays 0.
REQ-032 irq_ack held in PEND while flag_valid with flag_in=0001 same cycle -> flag_sticky bit0=1 after edge; irq re-asserts 2 cycles after irq_ack release.
REQ-033 clr and flag_valid with flag_in=1000 same cycle, sticky previously 0111 -> flag_sticky=1000, counter3=1, counters0..2=0.
REQ-034 CNT_W=4, 20 consecutive valid cycles flag_in=0010, rd_sel=1 -> cnt_out 15 and holds 15; rd_sel=0 -> cnt_out 0; macro undefined -> cnt_out 0 throughout.
REQ-035 reset asserted in HOLD with irq_ack=1 and sticky=1111 -> all outputs 0 next cycle; irq stays 0 until new masked capture.
